// File: rtl/tcdm2axi_bridge_if.sv
// Signal bundle between a TCDM initiator, the TCDM-to-AXI bridge and a single-beat AXI slave.
// The bridge uses the master modport; the TCDM initiator plus AXI slave side uses the slave modport.
interface tcdm2axi_bridge_if #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64
);
  // TCDM request / response
  logic                          req_i;
  logic [ADDR_WIDTH-1:0]         add_i;
  logic                          wen_i;
  logic [DATA_WIDTH-1:0]         wdata_i;
  logic [DATA_WIDTH/8-1:0]       be_i;
  logic                          gnt_o;
  logic                          r_valid_o;
  logic [DATA_WIDTH-1:0]         r_rdata_o;
  logic                          r_opc_o;
  // AXI write address / data / response
  logic [ADDR_WIDTH-1:0]         aw_addr_o;
  logic                          aw_valid_o;
  logic                          aw_ready_i;
  logic [AXI_DATA_WIDTH-1:0]     w_data_o;
  logic [AXI_DATA_WIDTH/8-1:0]   w_strb_o;
  logic                          w_valid_o;
  logic                          w_ready_i;
  logic [1:0]                    b_resp_i;
  logic                          b_valid_i;
  logic                          b_ready_o;
  // AXI read address / data
  logic [ADDR_WIDTH-1:0]         ar_addr_o;
  logic                          ar_valid_o;
  logic                          ar_ready_i;
  logic [AXI_DATA_WIDTH-1:0]     r_data_i;
  logic [1:0]                    r_resp_i;
  logic                          r_valid_i;
  logic                          r_ready_o;
  logic                          busy_o;

  modport master (
    input  req_i, add_i, wen_i, wdata_i, be_i,
    output gnt_o, r_valid_o, r_rdata_o, r_opc_o,
    output aw_addr_o, aw_valid_o, input aw_ready_i,
    output w_data_o, w_strb_o, w_valid_o, input w_ready_i,
    input  b_resp_i, b_valid_i, output b_ready_o,
    output ar_addr_o, ar_valid_o, input ar_ready_i,
    input  r_data_i, r_resp_i, r_valid_i, output r_ready_o,
    output busy_o
  );

  modport slave (
    output req_i, add_i, wen_i, wdata_i, be_i,
    input  gnt_o, r_valid_o, r_rdata_o, r_opc_o,
    input  aw_addr_o, aw_valid_o, output aw_ready_i,
    input  w_data_o, w_strb_o, w_valid_o, output w_ready_i,
    output b_resp_i, b_valid_i, input b_ready_o,
    input  ar_addr_o, ar_valid_o, output ar_ready_i,
    output r_data_i, r_resp_i, r_valid_i, input r_ready_o,
    input  busy_o
  );
endinterface

// File: rtl/tcdm2axi_bridge.sv
// TCDM to AXI bridge: one outstanding single-beat AXI read or write per TCDM request.
// Optional macro TCDM2AXI_ERR_EN reports SLVERR/DECERR responses on r_opc_o.
module tcdm2axi_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  tcdm2axi_bridge_if.master     bus
);

  localparam int unsigned DBYTES   = DATA_WIDTH / 8;
  localparam int unsigned ABYTES   = AXI_DATA_WIDTH / 8;
  localparam int unsigned NLANES   = AXI_DATA_WIDTH / DATA_WIDTH;
  localparam int unsigned LANE_W   = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam int unsigned LANE_LSB = $clog2(DBYTES);

  typedef enum logic [2:0] {IDLE, AR, RWAIT, AWW, BWAIT} state_t;

  state_t                     r_state;
  logic [ADDR_WIDTH-1:0]      r_addr;
  logic [AXI_DATA_WIDTH-1:0]  r_w_data;
  logic [ABYTES-1:0]          r_w_strb;
  logic                       r_ar_valid;
  logic                       r_aw_valid;
  logic                       r_w_valid;
  logic                       r_r_ready;
  logic                       r_b_ready;
  logic                       r_rvalid;
  logic [DATA_WIDTH-1:0]      r_rdata;
  logic                       r_opc;

  logic                       w_gnt;
  logic [LANE_W-1:0]          w_add_lane;
  logic [LANE_W-1:0]          w_cap_lane;
  logic [AXI_DATA_WIDTH-1:0]  w_place_data;
  logic [ABYTES-1:0]          w_place_strb;
  logic [DATA_WIDTH-1:0]      w_lane_rdata;
  logic                       w_aw_done;
  logic                       w_w_done;
  logic                       w_r_err;
  logic                       w_b_err;

  // Lane of the AXI beat that a TCDM word address falls into
  function automatic logic [LANE_W-1:0] lane_of(input logic [ADDR_WIDTH-1:0] a);
    if (NLANES > 1) return LANE_W'(a >> LANE_LSB);
    else            return '0;
  endfunction

  assign w_add_lane = lane_of(bus.add_i);
  assign w_cap_lane = lane_of(r_addr);

  // Reset blocks the grant so a request is never accepted and then discarded
  assign w_gnt = bus.req_i && (r_state == IDLE) && !rst_i;

  // A channel is done once its handshake fires now or has already fired
  assign w_aw_done = !r_aw_valid || bus.aw_ready_i;
  assign w_w_done  = !r_w_valid  || bus.w_ready_i;

`ifdef TCDM2AXI_ERR_EN
  // SLVERR (2) and DECERR (3) both have bit 1 set
  assign w_r_err = bus.r_resp_i[1];
  assign w_b_err = bus.b_resp_i[1];
`else
  assign w_r_err = 1'b0;
  assign w_b_err = 1'b0;
`endif

  // Write-lane placement of the incoming word and read-lane extraction of the returned beat
  always_comb begin
    w_place_data = '0;
    w_place_strb = '0;
    w_lane_rdata = '0;
    for (int unsigned i = 0; i < NLANES; i++) begin
      if (LANE_W'(i) == w_add_lane) begin
        w_place_data[i*DATA_WIDTH +: DATA_WIDTH] = bus.wdata_i;
        w_place_strb[i*DBYTES +: DBYTES]         = bus.be_i;
      end
      if (LANE_W'(i) == w_cap_lane) begin
        w_lane_rdata = bus.r_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Transaction FSM with registered handshake outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
      r_ar_valid <= 1'b0;
      r_aw_valid <= 1'b0;
      r_w_valid  <= 1'b0;
      r_r_ready  <= 1'b0;
      r_b_ready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_opc      <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_opc    <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_gnt) begin
            r_addr   <= bus.add_i;
            r_w_data <= w_place_data;
            r_w_strb <= w_place_strb;
            if (bus.wen_i) begin
              r_ar_valid <= 1'b1;
              r_state    <= AR;
            end else begin
              r_aw_valid <= 1'b1;
              r_w_valid  <= 1'b1;
              r_state    <= AWW;
            end
          end
        end
        AR: begin
          if (bus.ar_ready_i) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
            r_state    <= RWAIT;
          end
        end
        RWAIT: begin
          if (bus.r_valid_i) begin
            r_r_ready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_lane_rdata;
            r_opc     <= w_r_err;
            r_state   <= IDLE;
          end
        end
        AWW: begin
          if (bus.aw_ready_i) r_aw_valid <= 1'b0;
          if (bus.w_ready_i)  r_w_valid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_b_ready <= 1'b1;
            r_state   <= BWAIT;
          end
        end
        BWAIT: begin
          if (bus.b_valid_i) begin
            r_b_ready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= '0;
            r_opc     <= w_b_err;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_o      = w_gnt;
  assign bus.r_valid_o  = r_rvalid;
  assign bus.r_rdata_o  = r_rdata;
  assign bus.r_opc_o    = r_opc;
  assign bus.aw_addr_o  = r_addr;
  assign bus.aw_valid_o = r_aw_valid;
  assign bus.w_data_o   = r_w_data;
  assign bus.w_strb_o   = r_w_strb;
  assign bus.w_valid_o  = r_w_valid;
  assign bus.b_ready_o  = r_b_ready;
  assign bus.ar_addr_o  = r_addr;
  assign bus.ar_valid_o = r_ar_valid;
  assign bus.r_ready_o  = r_r_ready;
  assign bus.busy_o     = (r_state != IDLE);

endmodule

// File: tb/tb_tcdm2axi_bridge.sv
// Bench for tcdm2axi_bridge: directed vector table, reset-abort sequence and random transactions
// checked against a cycle-level protocol model of the expected bridge behaviour.
module tb_tcdm2axi_bridge;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned ADW = 64;
`ifdef TCDM2AXI_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [63:0] rdata;
    logic [1:0]  resp;
    int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
    logic        keep_req, pregranted;
    logic [63:0] e_bus;
    logic [7:0]  e_strb;
    logic [31:0] e_rd;
    logic        e_opc;
    int          e_lat;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  tcdm2axi_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AXI_DATA_WIDTH(ADW)) bus ();

  tcdm2axi_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AXI_DATA_WIDTH(ADW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input logic [63:0] rdata, input logic [1:0] resp,
                              input int ar_d, input int r_d, input int aw_d, input int w_d, input int b_d,
                              input logic keep, input logic pre, input logic [63:0] e_bus,
                              input logic [7:0] e_strb, input logic [31:0] e_rd, input logic e_opc,
                              input int e_lat);
    txn_t t;
    t.wen = wen; t.addr = addr; t.wdata = wdata; t.be = be; t.rdata = rdata; t.resp = resp;
    t.ar_dly = ar_d; t.r_dly = r_d; t.aw_dly = aw_d; t.w_dly = w_d; t.b_dly = b_d;
    t.keep_req = keep; t.pregranted = pre;
    t.e_bus = e_bus; t.e_strb = e_strb; t.e_rd = e_rd; t.e_opc = e_opc; t.e_lat = e_lat;
    return t;
  endfunction

  // Reference: 32-bit word lane inside a 64-bit beat is address bit 2
  function automatic txn_t with_model(input txn_t t);
    txn_t r;
    int   ln;
    r  = t;
    ln = int'((t.addr / 4) % 2);
    r.e_bus  = t.wen ? 64'h0 : (64'(t.wdata) << (32 * ln));
    r.e_strb = t.wen ? 8'h0  : (8'(t.be) << (4 * ln));
    r.e_rd   = t.wen ? 32'(t.rdata >> (32 * ln)) : 32'h0;
    r.e_opc  = ERR_ON && (t.resp >= 2'd2);
    r.e_lat  = 0;
    return r;
  endfunction

  // One TCDM transaction; the slave side answers with the delays in the record
  task automatic run_txn(input txn_t t);
    logic ar_d, r_d, aw_d, w_d, b_d, both, resp_done, fin;
    int   hs, cyc;
    ar_d = 0; r_d = 0; aw_d = 0; w_d = 0; b_d = 0; fin = 0; hs = 0; cyc = 0;
    if (!t.pregranted) begin
      @(posedge clk); #1;
      bus.req_i = 1'b1; bus.add_i = t.addr; bus.wen_i = t.wen;
      bus.wdata_i = t.wdata; bus.be_i = t.be;
    end
    bus.r_data_i = t.rdata; bus.r_resp_i = t.resp; bus.b_resp_i = t.resp;
    bus.ar_ready_i = 0; bus.r_valid_i = 0; bus.aw_ready_i = 0; bus.w_ready_i = 0; bus.b_valid_i = 0;
    if (!t.pregranted) begin
      @(negedge clk);
      chk("gnt_idle", 64'(bus.gnt_o), 64'd1);
      chk("rvalid_before", 64'(bus.r_valid_o), 64'd0);
    end
    while (!fin) begin
      @(posedge clk); #1;
      cyc++;
      bus.req_i      = t.keep_req;
      bus.ar_ready_i = t.wen && !ar_d && (cyc >= 1 + t.ar_dly);
      bus.r_valid_i  = t.wen && ar_d && !r_d && (cyc >= hs + 1 + t.r_dly);
      bus.aw_ready_i = !t.wen && !aw_d && (cyc >= 1 + t.aw_dly);
      bus.w_ready_i  = !t.wen && !w_d && (cyc >= 1 + t.w_dly);
      bus.b_valid_i  = !t.wen && aw_d && w_d && !b_d && (cyc >= hs + 1 + t.b_dly);
      @(negedge clk);
      resp_done = t.wen ? r_d : b_d;
      both      = aw_d && w_d;
      chk("r_valid", 64'(bus.r_valid_o), 64'(resp_done));
      chk("busy", 64'(bus.busy_o), 64'(!resp_done));
      chk("gnt_busy", 64'(bus.gnt_o), 64'(t.keep_req && resp_done));
      if (t.wen) begin
        chk("ar_valid", 64'(bus.ar_valid_o), 64'(!ar_d));
        if (!ar_d) chk("ar_addr", 64'(bus.ar_addr_o), 64'(t.addr));
        chk("r_ready", 64'(bus.r_ready_o), 64'(ar_d && !r_d));
        chk("aw_valid_rd", 64'(bus.aw_valid_o), 64'd0);
        chk("w_valid_rd", 64'(bus.w_valid_o), 64'd0);
        chk("b_ready_rd", 64'(bus.b_ready_o), 64'd0);
      end else begin
        chk("aw_valid", 64'(bus.aw_valid_o), 64'(!aw_d));
        chk("w_valid", 64'(bus.w_valid_o), 64'(!w_d));
        if (!aw_d) chk("aw_addr", 64'(bus.aw_addr_o), 64'(t.addr));
        if (!w_d) begin
          chk("w_data", bus.w_data_o, t.e_bus);
          chk("w_strb", 64'(bus.w_strb_o), 64'(t.e_strb));
        end
        chk("b_ready", 64'(bus.b_ready_o), 64'(both && !b_d));
        chk("ar_valid_wr", 64'(bus.ar_valid_o), 64'd0);
        chk("r_ready_wr", 64'(bus.r_ready_o), 64'd0);
      end
      if (resp_done) begin
        chk("r_rdata", 64'(bus.r_rdata_o), 64'(t.e_rd));
        chk("r_opc", 64'(bus.r_opc_o), 64'(t.e_opc));
        if (t.e_lat != 0) chk("latency", 64'(cyc), 64'(t.e_lat));
        fin = 1;
      end
      if (t.wen) begin
        if (ar_d && !r_d && bus.r_valid_i) r_d = 1;
        if (!ar_d && bus.ar_ready_i) begin ar_d = 1; hs = cyc; end
      end else begin
        if (!aw_d && bus.aw_ready_i) aw_d = 1;
        if (!w_d && bus.w_ready_i) w_d = 1;
        if (!both && aw_d && w_d) hs = cyc;
        else if (both && bus.b_valid_i) b_d = 1;
      end
      if (!fin && cyc >= 64) begin
        n_chk++; n_fail++;
        $display("FAIL txn_timeout: no response after %0d cycles, addr 0x%0h", cyc, t.addr);
        fin = 1;
      end
    end
  endtask

  initial begin
    txn_t dir [9];
    txn_t t;
    bus.req_i = 1'b1; bus.add_i = '0; bus.wen_i = 1'b0; bus.wdata_i = '0; bus.be_i = '0;
    bus.aw_ready_i = 0; bus.w_ready_i = 0; bus.b_resp_i = 0; bus.b_valid_i = 0;
    bus.ar_ready_i = 0; bus.r_data_i = '0; bus.r_resp_i = 0; bus.r_valid_i = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 64'(bus.gnt_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_r_valid", 64'(bus.r_valid_o), 64'd0);
    chk("rst_r_opc", 64'(bus.r_opc_o), 64'd0);
    chk("rst_r_rdata", 64'(bus.r_rdata_o), 64'd0);
    chk("rst_valids", 64'({bus.ar_valid_o, bus.aw_valid_o, bus.w_valid_o}), 64'd0);
    chk("rst_readys", 64'({bus.r_ready_o, bus.b_ready_o}), 64'd0);
    chk("rst_w_strb", 64'(bus.w_strb_o), 64'd0);
    chk("rst_ar_addr", 64'(bus.ar_addr_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.req_i = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(bus.busy_o), 64'd0);

    //          wen   addr           wdata          be    rdata                  rsp ar r aw w b keep pre e_bus                  strb   e_rd           opc     lat
    dir[0] = mk(1'b1, 32'h1000_0004, 32'h0,         4'h0, 64'h1111_2222_3333_4444, 2'd0, 0,0,0,0,0, 0,0, 64'h0,                 8'h00, 32'h1111_2222, 1'b0,   3);
    dir[1] = mk(1'b0, 32'h1000_0000, 32'hDEADBEEF,  4'hF, 64'h0,                 2'd0, 0,0,0,3,0, 0,0, 64'h0000_0000_DEAD_BEEF, 8'h0F, 32'h0,  1'b0,   6);
    dir[2] = mk(1'b0, 32'h1000_0004, 32'hCAFEF00D,  4'h3, 64'h0,                 2'd0, 0,0,0,0,2, 1,0, 64'hCAFE_F00D_0000_0000, 8'h30, 32'h0,  1'b0,   5);
    dir[3] = mk(1'b0, 32'h1000_0004, 32'hCAFEF00D,  4'h3, 64'h0,                 2'd0, 0,0,0,0,0, 0,1, 64'hCAFE_F00D_0000_0000, 8'h30, 32'h0,  1'b0,   3);
    dir[4] = mk(1'b1, 32'h2000_0000, 32'h0,         4'h0, 64'hAAAA_BBBB_CCCC_DDDD, 2'd0, 2,1,0,0,0, 0,0, 64'h0,                 8'h00, 32'hCCCC_DDDD, 1'b0,   6);
    dir[5] = mk(1'b0, 32'h0000_0008, 32'h1234_5678, 4'hF, 64'h0,                 2'd2, 0,0,0,0,0, 0,0, 64'h0000_0000_1234_5678, 8'h0F, 32'h0,  ERR_ON, 3);
    dir[6] = mk(1'b1, 32'h0000_000C, 32'h0,         4'h0, 64'h0123_4567_89AB_CDEF, 2'd3, 0,0,0,0,0, 0,0, 64'h0,                 8'h00, 32'h0123_4567, ERR_ON, 3);
    dir[7] = mk(1'b0, 32'h4000_0004, 32'h55AA_55AA, 4'h9, 64'h0,                 2'd0, 0,0,2,0,0, 0,0, 64'h55AA_55AA_0000_0000, 8'h90, 32'h0,  1'b0,   5);
    dir[8] = mk(1'b1, 32'h5000_0000, 32'h0,         4'h0, 64'hFFFF_0000_8765_4321, 2'd1, 0,0,0,0,0, 0,0, 64'h0,                 8'h00, 32'h8765_4321, 1'b0,   3);
    for (int i = 0; i < 9; i++) run_txn(dir[i]);

    // Reset while waiting for read data, with r_valid arriving in the same cycle
    @(posedge clk); #1;
    bus.req_i = 1'b1; bus.wen_i = 1'b1; bus.add_i = 32'h3000_0004;
    @(negedge clk);
    chk("abort_gnt", 64'(bus.gnt_o), 64'd1);
    @(posedge clk); #1;
    bus.req_i = 1'b0; bus.ar_ready_i = 1'b1;
    @(negedge clk);
    chk("abort_ar_valid", 64'(bus.ar_valid_o), 64'd1);
    @(posedge clk); #1;
    bus.ar_ready_i = 1'b0; bus.r_valid_i = 1'b1; bus.r_data_i = 64'h9999_8888_7777_6666; rst = 1'b1;
    @(negedge clk);
    chk("abort_r_ready", 64'(bus.r_ready_o), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0; bus.r_valid_i = 1'b0;
    @(negedge clk);
    chk("abort_ar", 64'({bus.ar_valid_o, bus.r_ready_o}), 64'd0);
    chk("abort_busy", 64'(bus.busy_o), 64'd0);
    chk("abort_r_valid", 64'(bus.r_valid_o), 64'd0);
    chk("abort_ar_addr", 64'(bus.ar_addr_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_no_rvalid", 64'(bus.r_valid_o), 64'd0);
    run_txn(dir[0]);

    for (int i = 0; i < 40; i++) begin
      t.wen    = 1'($urandom_range(0, 1));
      t.addr   = $urandom;
      t.wdata  = $urandom;
      t.be     = 4'($urandom_range(0, 15));
      t.rdata  = {$urandom, $urandom};
      t.resp   = 2'($urandom_range(0, 3));
      t.ar_dly = int'($urandom_range(0, 3));
      t.r_dly  = int'($urandom_range(0, 3));
      t.aw_dly = int'($urandom_range(0, 3));
      t.w_dly  = int'($urandom_range(0, 3));
      t.b_dly  = int'($urandom_range(0, 3));
      t.keep_req = 1'b0;
      t.pregranted = 1'b0;
      run_txn(with_model(t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks done", n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tcdm2axi_bridge.md
TCDM2AXI_BRIDGE -- requirements
Module: tcdm2axi_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: TCDM and AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: TCDM data width.
REQ-003 SHALL have parameter AXI_DATA_WIDTH, default 64: AXI data width, integer multiple of DATA_WIDTH.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have the following ports (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  TCDM request
- add_i  in  ADDR_WIDTH  byte address
- wen_i  in  1  1=read, 0=write
- wdata_i  in  DATA_WIDTH  write data
- be_i  in  DATA_WIDTH/8  byte enables
- gnt_o  out  1  request accepted
- r_valid_o  out  1  response valid
- r_rdata_o  out  DATA_WIDTH  read data
- r_opc_o  out  1  error flag
- aw_addr_o  out  ADDR_WIDTH;  aw_valid_o  out  1;  aw_ready_i  in  1
- w_data_o  out  AXI_DATA_WIDTH;  w_strb_o  out  AXI_DATA_WIDTH/8;  w_valid_o  out  1;  w_ready_i  in  1
- b_resp_i  in  2;  b_valid_i  in  1;  b_ready_o  out  1
- ar_addr_o  out  ADDR_WIDTH;  ar_valid_o  out  1;  ar_ready_i  in  1
- r_data_i  in  AXI_DATA_WIDTH;  r_resp_i  in  2;  r_valid_i  in  1;  r_ready_o  out  1
- busy_o  out  1  transaction in flight

Function
REQ-006 SHALL issue single-beat AXI transactions only (len 0, size DATA_WIDTH/8, INCR, fixed ID; the integrator ties these fields), with one outstanding transaction at most.
REQ-007 SHALL use FSM states IDLE, AR, RWAIT, AWW, BWAIT.
REQ-008 SHALL assert gnt_o combinationally when req_i=1 and state=IDLE; on grant, register add_i, wen_i, wdata_i and be_i, then go to AR if wen_i=1, else AWW.
REQ-009 AR: SHALL assert ar_valid_o with ar_addr_o equal to the captured address; on ar_ready_i go to RWAIT.
REQ-010 RWAIT: SHALL assert r_ready_o=1; on r_valid_i go to IDLE and capture the lane r_data_i[lane*DATA_WIDTH +: DATA_WIDTH], where lane = add[log2(AXI_DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)].
REQ-011 AWW: SHALL assert aw_valid_o and w_valid_o independently from the first AWW cycle, and deassert each one after its own handshake; go to BWAIT once both handshakes are done, including both in the same cycle.
REQ-012 SHALL place wdata in lane `lane` of w_data_o and be in the matching strb bits, with all other strb bits 0 and other data bits 0.
REQ-013 BWAIT: SHALL assert b_ready_o=1; on b_valid_i go to IDLE.
REQ-014 SHALL hold every valid with stable payload until ready; SHALL never deassert a valid before its handshake.
REQ-015 SHALL pulse r_valid_o for exactly one cycle, the cycle after the R or B handshake; for writes r_rdata_o=0.
REQ-016 A new grant MAY occur in the same cycle r_valid_o is high.
REQ-017 Minimum latency with always-ready slave: read grant at cycle 0, AR at 1, R at 2, r_valid_o at 3; write grant at 0, AW+W at 1, B at 2, r_valid_o at 3.
REQ-018 busy_o SHALL be 1 whenever state != IDLE.

Reset
REQ-019 On rst_i=1 at a clock edge SHALL enter IDLE and drive all valids, readys, gnt_o, r_valid_o, r_opc_o, busy_o, r_rdata_o and the captured registers to 0, including mid-transaction; an aborted transaction SHALL produce no r_valid_o.

Configuration
REQ-020 With TCDM2AXI_ERR_EN defined: r_opc_o SHALL be registered with r_valid_o and equal 1 iff the captured r_resp_i or b_resp_i is SLVERR (2) or DECERR (3).
REQ-021 Without TCDM2AXI_ERR_EN: r_opc_o SHALL be constant 0 and resp inputs SHALL be ignored.

Verification
REQ-022 Read add=0x1000_0004, ar_ready/r_valid immediate, r_data=0x1111_2222_3333_4444 -> ar_addr=0x1000_0004, r_valid_o at cycle 3, r_rdata_o=0x1111_2222.
REQ-023 Write add=0x1000_0000, wdata=0xDEADBEEF, be=0xF; aw_ready 3 cycles before w_ready -> w_strb=0x0F, w_data low=0xDEADBEEF, single r_valid_o after B.
REQ-024 Write add=0x...04, be=0x3 -> w_strb=0x30; req_i held during busy -> gnt_o=0 until IDLE.
REQ-025 Reset asserted in RWAIT -> next cycle ar/r signals 0, busy_o=0, no r_valid_o; next request serviced normally.
REQ-026 ERR_EN on, b_resp=2 -> r_opc_o=1 with r_valid_o; ERR_EN off -> r_opc_o=0.
